// File: rtl/miriscv_lsu_pkg.sv
// Load/store and memory-arbitration types shared by the LSU-side blocks.
package miriscv_lsu_pkg;

    import miriscv_pkg::XLEN;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_master_e;

    // Request payload presented on the shared memory port
    typedef struct packed {
        logic              we;
        logic [XLEN/8-1:0] be;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide constants shared by the miriscv blocks.
package miriscv_pkg;

    localparam int unsigned XLEN = 32;

endpackage

// File: rtl/miriscv_arb_id_fifo.sv
// Small in-order ID tracker: records who issued each outstanding transaction.
module miriscv_arb_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_id_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_ff;
    logic [PTR_W-1:0] rd_ptr_ff;
    logic [CNT_W-1:0] count_ff;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o  = (count_ff == CNT_W'(DEPTH));
    assign empty_o = (count_ff == '0);
    assign head_o  = mem_q[rd_ptr_ff];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_ff <= '0;
            rd_ptr_ff <= '0;
            count_ff  <= '0;
        end else begin
            if (do_push) wr_ptr_ff <= next_ptr(wr_ptr_ff);
            if (do_pop)  rd_ptr_ff <= next_ptr(rd_ptr_ff);
            case ({do_push, do_pop})
                2'b10:   count_ff <= count_ff + CNT_W'(1);
                2'b01:   count_ff <= count_ff - CNT_W'(1);
                default: count_ff <= count_ff;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_ff] <= push_id_i;
    end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares one memory port between the fetch and data interfaces; responses
// return in order and are steered by the recorded issuer ID.
module miriscv_mem_arbiter
    import miriscv_pkg::*;
    import miriscv_lsu_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2,
    parameter bit          DATA_PRIO   = 1'b1
) (
    input  logic              clk_i,
    input  logic              arstn_i,

    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,

    output logic              err_o
);

    arb_master_e winner;
    arb_master_e sel_ff;
    arb_master_e last_ff;
    logic        locked_ff;
    logic        err_ff;
    logic        full;
    logic        empty;
    logic [0:0]  head_id;
    logic        issue;
    logic        accept;
    logic        pop;
    mem_req_t    req_mux;

    // A stalled request keeps its grant slot; otherwise priority or round-robin
    always_comb begin
        winner = ARB_INSTR;
        if (locked_ff) begin
            winner = sel_ff;
        end else if (instr_req_i && data_req_i) begin
            if (DATA_PRIO) winner = ARB_DATA;
            else           winner = (last_ff == ARB_DATA) ? ARB_INSTR : ARB_DATA;
        end else if (data_req_i) begin
            winner = ARB_DATA;
        end
    end

    assign issue  = (instr_req_i | data_req_i) & ~full;
    assign accept = issue & mem_gnt_i;
    assign pop    = mem_rvalid_i & ~empty;

    always_comb begin
        req_mux = '0;
        if (issue) begin
            if (winner == ARB_DATA) begin
                req_mux.we    = data_we_i;
                req_mux.be    = data_be_i;
                req_mux.addr  = data_addr_i;
                req_mux.wdata = data_wdata_i;
            end else begin
                req_mux.be    = '1;
                req_mux.addr  = instr_addr_i;
            end
        end
    end

    assign mem_req_o      = issue;
    assign mem_we_o       = req_mux.we;
    assign mem_be_o       = req_mux.be;
    assign mem_addr_o     = req_mux.addr;
    assign mem_wdata_o    = req_mux.wdata;

    assign instr_gnt_o    = accept & (winner == ARB_INSTR);
    assign data_gnt_o     = accept & (winner == ARB_DATA);
    assign instr_rvalid_o = pop & (head_id == 1'(ARB_INSTR));
    assign data_rvalid_o  = pop & (head_id == 1'(ARB_DATA));
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign err_o          = err_ff;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            locked_ff <= 1'b0;
            sel_ff    <= ARB_INSTR;
            last_ff   <= ARB_INSTR;
            err_ff    <= 1'b0;
        end else begin
            if (accept) begin
                locked_ff <= 1'b0;
                last_ff   <= winner;
            end else if (issue) begin
                locked_ff <= 1'b1;
                sel_ff    <= winner;
            end
            if (mem_rvalid_i && empty) err_ff <= 1'b1;
        end
    end

    miriscv_arb_id_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .push_i    (accept),
        .push_id_i (1'(winner)),
        .pop_i     (pop),
        .full_o    (full),
        .empty_o   (empty),
        .head_o    (head_id)
    );

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench for miriscv_mem_arbiter: a round-robin and a data-priority instance,
// both checked every cycle against a queue-based reference model.
module tb_miriscv_mem_arbiter;

    import miriscv_pkg::*;

    localparam int unsigned OUT = 2;

    logic            clk;
    logic            arstn;

    logic            instr_req   [2];
    logic [XLEN-1:0] instr_addr  [2];
    logic            instr_gnt   [2];
    logic            instr_rvalid[2];
    logic [XLEN-1:0] instr_rdata [2];
    logic            data_req    [2];
    logic            data_we     [2];
    logic [3:0]      data_be     [2];
    logic [XLEN-1:0] data_addr   [2];
    logic [XLEN-1:0] data_wdata  [2];
    logic            data_gnt    [2];
    logic            data_rvalid [2];
    logic [XLEN-1:0] data_rdata  [2];
    logic            mem_req     [2];
    logic            mem_we      [2];
    logic [3:0]      mem_be      [2];
    logic [XLEN-1:0] mem_addr    [2];
    logic [XLEN-1:0] mem_wdata   [2];
    logic            mem_gnt     [2];
    logic            mem_rvalid  [2];
    logic [XLEN-1:0] mem_rdata   [2];
    logic            err         [2];

    // Reference model state: issuer queue (0 = fetch, 1 = data) and arbitration memory
    bit q [2][$];
    bit locked_m[2], sel_m[2], last_m[2], err_m[2];
    bit e_igt[2], e_dgt[2];

    logic            obs_mreq[2], obs_mwe[2], obs_igt[2], obs_dgnt[2];
    logic            obs_irv[2], obs_drv[2], obs_err[2];
    logic [XLEN-1:0] obs_maddr[2], obs_drdata[2];

    int n_pass  = 0;
    int n_total = 0;

    logic iwait[2], dwait[2];

    miriscv_mem_arbiter #(.OUTSTANDING(OUT), .DATA_PRIO(1'b0)) u_rr (
        .clk_i(clk), .arstn_i(arstn),
        .instr_req_i(instr_req[0]), .instr_addr_i(instr_addr[0]), .instr_gnt_o(instr_gnt[0]),
        .instr_rvalid_o(instr_rvalid[0]), .instr_rdata_o(instr_rdata[0]),
        .data_req_i(data_req[0]), .data_we_i(data_we[0]), .data_be_i(data_be[0]),
        .data_addr_i(data_addr[0]), .data_wdata_i(data_wdata[0]), .data_gnt_o(data_gnt[0]),
        .data_rvalid_o(data_rvalid[0]), .data_rdata_o(data_rdata[0]),
        .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_be_o(mem_be[0]),
        .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_gnt_i(mem_gnt[0]),
        .mem_rvalid_i(mem_rvalid[0]), .mem_rdata_i(mem_rdata[0]), .err_o(err[0])
    );

    miriscv_mem_arbiter #(.OUTSTANDING(OUT), .DATA_PRIO(1'b1)) u_prio (
        .clk_i(clk), .arstn_i(arstn),
        .instr_req_i(instr_req[1]), .instr_addr_i(instr_addr[1]), .instr_gnt_o(instr_gnt[1]),
        .instr_rvalid_o(instr_rvalid[1]), .instr_rdata_o(instr_rdata[1]),
        .data_req_i(data_req[1]), .data_we_i(data_we[1]), .data_be_i(data_be[1]),
        .data_addr_i(data_addr[1]), .data_wdata_i(data_wdata[1]), .data_gnt_o(data_gnt[1]),
        .data_rvalid_o(data_rvalid[1]), .data_rdata_o(data_rdata[1]),
        .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_be_o(mem_be[1]),
        .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_gnt_i(mem_gnt[1]),
        .mem_rvalid_i(mem_rvalid[1]), .mem_rdata_i(mem_rdata[1]), .err_o(err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // A master must hold its request until it is granted
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (arstn && iwait[k] && !instr_req[k])
                $error("FAIL protocol_instr[%0d] observed=0 expected=1", k);
            if (arstn && dwait[k] && !data_req[k])
                $error("FAIL protocol_data[%0d] observed=0 expected=1", k);
            iwait[k] <= arstn && instr_req[k] && !instr_gnt[k];
            dwait[k] <= arstn && data_req[k] && !data_gnt[k];
        end
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            instr_req[k] = 1'b0; instr_addr[k] = '0;
            data_req[k] = 1'b0; data_we[k] = 1'b0; data_be[k] = '0;
            data_addr[k] = '0; data_wdata[k] = '0;
            mem_gnt[k] = 1'b0; mem_rvalid[k] = 1'b0; mem_rdata[k] = '0;
        end
    endtask

    // Compare both DUTs against the model mid-cycle, then advance the model
    task automatic cycle();
        bit              full, req, acc, pop, win;
        logic            e_we;
        logic [3:0]      e_be;
        logic [XLEN-1:0] e_addr, e_wdata;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!arstn) begin
                q[k].delete();
                locked_m[k] = 0; sel_m[k] = 0; last_m[k] = 0; err_m[k] = 0;
            end
            full = (q[k].size() == OUT);
            req  = (instr_req[k] || data_req[k]) && !full;
            if (locked_m[k])                    win = sel_m[k];
            else if (instr_req[k] && data_req[k]) win = (k == 1) ? 1'b1 : !last_m[k];
            else                                 win = data_req[k];
            e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
            if (req && win)  begin e_we = data_we[k]; e_be = data_be[k]; e_addr = data_addr[k]; e_wdata = data_wdata[k]; end
            if (req && !win) begin e_be = 4'hF; e_addr = instr_addr[k]; end
            acc = req && mem_gnt[k];
            pop = mem_rvalid[k] && (q[k].size() != 0);
            e_igt[k] = acc && !win;
            e_dgt[k] = acc && win;

            chk("mem_req",      k, 32'(mem_req[k]),      32'(req));
            chk("mem_we",       k, 32'(mem_we[k]),       32'(e_we));
            chk("mem_be",       k, 32'(mem_be[k]),       32'(e_be));
            chk("mem_addr",     k, mem_addr[k],          e_addr);
            chk("mem_wdata",    k, mem_wdata[k],         e_wdata);
            chk("instr_gnt",    k, 32'(instr_gnt[k]),    32'(e_igt[k]));
            chk("data_gnt",     k, 32'(data_gnt[k]),     32'(e_dgt[k]));
            chk("instr_rvalid", k, 32'(instr_rvalid[k]), 32'(pop && q[k][0] == 1'b0));
            chk("data_rvalid",  k, 32'(data_rvalid[k]),  32'(pop && q[k][0] == 1'b1));
            chk("instr_rdata",  k, instr_rdata[k],       mem_rdata[k]);
            chk("data_rdata",   k, data_rdata[k],        mem_rdata[k]);
            chk("err",          k, 32'(err[k]),          32'(err_m[k]));

            obs_mreq[k] = mem_req[k];  obs_mwe[k] = mem_we[k];   obs_maddr[k] = mem_addr[k];
            obs_igt[k]  = instr_gnt[k]; obs_dgnt[k] = data_gnt[k];
            obs_irv[k]  = instr_rvalid[k]; obs_drv[k] = data_rvalid[k];
            obs_drdata[k] = data_rdata[k]; obs_err[k] = err[k];

            if (arstn) begin
                if (mem_rvalid[k] && q[k].size() == 0) err_m[k] = 1;
                if (pop) void'(q[k].pop_front());
                if (acc) begin
                    q[k].push_back(win);
                    last_m[k] = win;
                    locked_m[k] = 0;
                end else if (req) begin
                    locked_m[k] = 1;
                    sel_m[k] = win;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin iwait[k] = 0; dwait[k] = 0; end
        idle();
        arstn = 1'b0;
        cycle();
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_req", k, 32'(obs_mreq[k]), 0);
            chk("rst_err",     k, 32'(obs_err[k]),  0);
        end
        arstn = 1'b1;
        cycle();

        // Single load: grant same cycle, response two cycles later
        for (int k = 0; k < 2; k++) begin
            data_req[k] = 1; data_be[k] = 4'hF; data_addr[k] = 32'h100; mem_gnt[k] = 1;
        end
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t1_dgnt",  k, 32'(obs_dgnt[k]), 1);
            chk("t1_maddr", k, obs_maddr[k], 32'h100);
        end
        idle();
        cycle();
        for (int k = 0; k < 2; k++) begin mem_rvalid[k] = 1; mem_rdata[k] = 32'hDEADBEEF; end
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t1_drv",    k, 32'(obs_drv[k]), 1);
            chk("t1_drdata", k, obs_drdata[k], 32'hDEADBEEF);
            chk("t1_irv",    k, 32'(obs_irv[k]), 0);
        end
        idle();

        // Contention: round-robin alternates from data, priority starves fetch
        arstn = 1'b0;
        cycle();
        arstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 2; k++) begin
                instr_req[k] = (c < 4) || (k == 1); instr_addr[k] = 32'h2000;
                data_req[k]  = (c < 4) || (k == 0); data_addr[k]  = 32'h3000;
                data_be[k] = 4'hF; mem_gnt[k] = 1; mem_rvalid[k] = (c > 0);
                mem_rdata[k] = 32'h1111_0000 + 32'(c);
            end
            cycle();
            if (c < 4) begin
                chk("t2_rr_dgnt",   0, 32'(obs_dgnt[0]), 32'(c % 2 == 0));
                chk("t2_rr_igt",    0, 32'(obs_igt[0]),  32'(c % 2 == 1));
                chk("t2_prio_dgnt", 1, 32'(obs_dgnt[1]), 1);
                chk("t2_prio_igt",  1, 32'(obs_igt[1]),  0);
            end else begin
                chk("t2_rr_dgnt",   0, 32'(obs_dgnt[0]), 1);
                chk("t2_prio_igt",  1, 32'(obs_igt[1]),  1);
            end
            if (c > 0) begin
                chk("t2_rr_irv",    0, 32'(obs_irv[0]), 32'(c % 2 == 0));
                chk("t2_prio_drv",  1, 32'(obs_drv[1]), 1);
            end
        end
        idle();
        for (int k = 0; k < 2; k++) mem_rvalid[k] = 1;
        cycle();
        idle();

        // Stalled fetch keeps the port even when data arrives
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 2; k++) begin
                instr_req[k] = (c < 4); instr_addr[k] = 32'hA000;
                data_req[k] = (c >= 1); data_addr[k] = 32'hB000; data_we[k] = 1;
                data_be[k] = 4'h3; data_wdata[k] = 32'h5555AAAA; mem_gnt[k] = (c >= 3);
            end
            cycle();
            for (int k = 0; k < 2; k++) begin
                if (c < 4) chk("t3_maddr", k, obs_maddr[k], 32'hA000);
                if (c == 3) chk("t3_igt", k, 32'(obs_igt[k]), 1);
                if (c == 4) begin
                    chk("t3_dgnt", k, 32'(obs_dgnt[k]), 1);
                    chk("t3_maddr_data", k, obs_maddr[k], 32'hB000);
                    chk("t3_mwe", k, 32'(obs_mwe[k]), 1);
                end
            end
        end
        idle();

        // Tracker full: issue blocked even with a pop in the same cycle
        for (int k = 0; k < 2; k++) begin
            instr_req[k] = 1; instr_addr[k] = 32'hC000; mem_gnt[k] = 1; mem_rvalid[k] = 1;
        end
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t4_full_mreq", k, 32'(obs_mreq[k]), 0);
            chk("t4_full_igt",  k, 32'(obs_igt[k]),  0);
            chk("t4_full_irv",  k, 32'(obs_irv[k]),  1);
        end
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t4_pushpop_igt", k, 32'(obs_igt[k]), 1);
            chk("t4_pushpop_drv", k, 32'(obs_drv[k]), 1);
            instr_req[k] = 0;
        end
        cycle();
        for (int k = 0; k < 2; k++) chk("t4_last_irv", k, 32'(obs_irv[k]), 1);

        // Response with nothing outstanding
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t5_orphan_irv", k, 32'(obs_irv[k]), 0);
            chk("t5_orphan_drv", k, 32'(obs_drv[k]), 0);
        end
        idle();
        cycle();
        for (int k = 0; k < 2; k++) chk("t5_err_set", k, 32'(obs_err[k]), 1);
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t5_err_hold", k, 32'(obs_err[k]), 1);
            data_req[k] = 1; data_addr[k] = 32'hD000; data_be[k] = 4'hF; mem_gnt[k] = 1;
        end
        cycle();
        cycle();
        idle();
        arstn = 1'b0;
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t5_rst_err",  k, 32'(obs_err[k]),  0);
            chk("t5_rst_mreq", k, 32'(obs_mreq[k]), 0);
        end
        arstn = 1'b1;
        for (int k = 0; k < 2; k++) mem_rvalid[k] = 1;
        cycle();
        for (int k = 0; k < 2; k++) chk("t5_post_rst_drv", k, 32'(obs_drv[k]), 0);
        idle();
        cycle();
        for (int k = 0; k < 2; k++) chk("t5_post_rst_err", k, 32'(obs_err[k]), 1);
        arstn = 1'b0;
        cycle();
        arstn = 1'b1;
        cycle();

        // Random traffic with legal request holding
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (e_igt[k]) instr_req[k] = 0;
                if (e_dgt[k]) data_req[k] = 0;
                if (!instr_req[k] && ($urandom % 3 == 0)) begin
                    instr_req[k] = 1; instr_addr[k] = $urandom & 32'hFFFF_FFFC;
                end
                if (!data_req[k] && ($urandom % 3 == 0)) begin
                    data_req[k] = 1; data_we[k] = 1'($urandom);
                    data_be[k] = 4'($urandom_range(15, 1)); data_addr[k] = $urandom;
                    data_wdata[k] = $urandom;
                end
                mem_gnt[k]    = ($urandom % 4 != 0);
                mem_rvalid[k] = (q[k].size() != 0) && ($urandom % 2 == 0);
                mem_rdata[k]  = $urandom;
            end
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            if (e_igt[k]) instr_req[k] = 0;
            if (e_dgt[k]) data_req[k] = 0;
        end
        for (int n = 0; n < 8 && (instr_req[0] || data_req[0] || instr_req[1] || data_req[1]); n++) begin
            for (int k = 0; k < 2; k++) begin
                mem_gnt[k] = 1; mem_rvalid[k] = (q[k].size() != 0);
            end
            cycle();
            for (int k = 0; k < 2; k++) begin
                if (e_igt[k]) instr_req[k] = 0;
                if (e_dgt[k]) data_req[k] = 0;
            end
        end
        idle();
        for (int n = 0; n < 8 && (q[0].size() != 0 || q[1].size() != 0); n++) begin
            for (int k = 0; k < 2; k++) mem_rvalid[k] = (q[k].size() != 0);
            cycle();
        end
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
